// File: rtl/down_counter_pkg.sv
// Shared constants and helpers for the counter family.
// Used by the down-counter top, its subtractor and the bench.
package counter_pkg;

  localparam int COUNTER_WIDTH_DEFAULT = 8;
  localparam bit WRAP_MODE = 1'b1;
  localparam bit SAT_MODE  = 1'b0;

  function automatic logic [31:0] all_ones(input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/down_counter_if.sv
// Counting interface shared by a down-counter stage and its driver.
// The master drives requests; the slave returns registered state.
interface down_counter_if #(
  parameter int WIDTH = 8
);

  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             sub;
  logic [WIDTH-1:0] value_out;
  logic             borrow_out;
  logic             zero;

  modport master (
    output load,
    output load_value,
    output sub,
    input  value_out,
    input  borrow_out,
    input  zero
  );

  modport slave (
    input  load,
    input  load_value,
    input  sub,
    output value_out,
    output borrow_out,
    output zero
  );

endinterface

// File: rtl/down_counter_borrow_lookahead_subtractor.sv
// Borrow-lookahead subtractor: diff = x - y - b0.
// Each borrow is formed directly from generate/propagate terms.
module borrow_lookahead_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             b0_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   b;
  logic             acc;
  logic             run;

  // A bit generates a borrow when x=0,y=1 and passes one on when x==y.
  assign g = ~x_i & y_i;
  assign p = ~(x_i ^ y_i);

  always_comb begin
    b    = '0;
    b[0] = b0_i;
    acc  = 1'b0;
    run  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      acc = g[i];
      run = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (run & g[j]);
        run = run & p[j];
      end
      b[i+1] = acc | (run & b0_i);
    end
  end

  assign diff_o   = x_i ^ y_i ^ b[WIDTH-1:0];
  assign borrow_o = b[WIDTH];

endmodule

// File: rtl/down_counter.sv
// Loadable down-counter stage with registered borrow and zero flags.
// Priority per edge: reset, load, sub, hold.
module down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH_DEFAULT,
  parameter bit WRAP  = WRAP_MODE
) (
  input  logic           clock,
  input  logic           reset,
  down_counter_if.slave  bus
);

  logic [WIDTH-1:0] value_q, value_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] diff;
  logic             sub_borrow;

  borrow_lookahead_subtractor #(
    .WIDTH (WIDTH)
  ) u_sub (
    .x_i      (value_q),
    .y_i      ({{(WIDTH-1){1'b0}}, 1'b1}),
    .b0_i     (1'b0),
    .diff_o   (diff),
    .borrow_o (sub_borrow)
  );

  always_comb begin
    value_d  = value_q;
    zero_d   = zero_q;
    borrow_d = 1'b0;
    if (bus.load) begin
      value_d = bus.load_value;
      zero_d  = (bus.load_value == '0);
    end else if (bus.sub) begin
      borrow_d = sub_borrow;
      // In saturate mode an underflow only pulses borrow.
      if (WRAP == WRAP_MODE || !sub_borrow) begin
        value_d = diff;
        zero_d  = (diff == '0);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_q  <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      value_q  <= value_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.value_out  = value_q;
  assign bus.borrow_out = borrow_q;
  assign bus.zero       = zero_q;

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: wrap and saturate stages plus a
// two-stage cascade, checked through an expected-value queue.
module tb_down_counter;
  import counter_pkg::*;

  logic clock;
  logic reset;

  down_counter_if #(.WIDTH(8)) w_if ();
  down_counter_if #(.WIDTH(8)) s_if ();
  down_counter_if #(.WIDTH(8)) lo_if ();
  down_counter_if #(.WIDTH(8)) hi_if ();

  down_counter #(.WIDTH(8), .WRAP(WRAP_MODE)) dut_w (
    .clock (clock), .reset (reset), .bus (w_if.slave));
  down_counter #(.WIDTH(8), .WRAP(SAT_MODE)) dut_s (
    .clock (clock), .reset (reset), .bus (s_if.slave));
  down_counter #(.WIDTH(8), .WRAP(WRAP_MODE)) dut_lo (
    .clock (clock), .reset (reset), .bus (lo_if.slave));
  down_counter #(.WIDTH(8), .WRAP(WRAP_MODE)) dut_hi (
    .clock (clock), .reset (reset), .bus (hi_if.slave));

  assign hi_if.sub = lo_if.borrow_out;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [7:0] lv;
    logic       sb;
    logic [7:0] ev;
    logic       eb;
    logic       ez;
  } vec_t;

  typedef struct {
    logic [15:0] v;
    logic        b;
    logic        z;
  } exp_t;

  vec_t tbl[17];
  exp_t sbq[$];
  int   vecs;
  int   errs;
  logic [7:0] ones8;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_pop(input string nm, input logic [15:0] v,
                           input logic b, input logic z);
    exp_t e;
    vecs++;
    if (sbq.size() == 0) begin
      errs++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sbq.pop_front();
      if (v !== e.v || b !== e.b || z !== e.z) begin
        errs++;
        $display("FAIL %s: got v=%h b=%b z=%b want v=%h b=%b z=%b",
                 nm, v, b, z, e.v, e.b, e.z);
      end
    end
  endtask

  task automatic push(input logic [15:0] v, input logic b, input logic z);
    exp_t e;
    e.v = v; e.b = b; e.z = z;
    sbq.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs  = 0;
    errs  = 0;
    ones8 = all_ones(8)[7:0];
    tbl[0]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'bx, 8'hxx, 1'bx, 8'h00, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 8'h03, 1'b0, 8'h03, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, ones8, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, ones8, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h05, 1'b0, 8'h05, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h80, 1'b1, 8'h80, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'h41, 1'b0, 8'h41, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};

    reset = 1'b1;
    w_if.load = 1'b0;  w_if.load_value = '0;  w_if.sub = 1'b0;
    s_if.load = 1'b0;  s_if.load_value = '0;  s_if.sub = 1'b0;
    lo_if.load = 1'b0; lo_if.load_value = '0; lo_if.sub = 1'b0;
    hi_if.load = 1'b0; hi_if.load_value = '0;

    for (int i = 0; i < 17; i++) begin
      reset           = tbl[i].rst;
      w_if.load       = tbl[i].ld;
      w_if.load_value = tbl[i].lv;
      w_if.sub        = tbl[i].sb;
      push({8'h00, tbl[i].ev}, tbl[i].eb, tbl[i].ez);
      tick();
      check_pop($sformatf("wrap_vec%0d", i),
                {8'h00, w_if.value_out}, w_if.borrow_out, w_if.zero);
    end
    w_if.load = 1'b0;
    w_if.sub  = 1'b0;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    s_if.load = 1'b1;
    s_if.load_value = 8'h01;
    push(16'h0001, 1'b0, 1'b0);
    tick();
    check_pop("sat_load", {8'h00, s_if.value_out},
              s_if.borrow_out, s_if.zero);
    s_if.load = 1'b0;
    s_if.sub  = 1'b1;
    push(16'h0000, 1'b0, 1'b1);
    push(16'h0000, 1'b1, 1'b1);
    push(16'h0000, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_pop($sformatf("sat_sub%0d", k), {8'h00, s_if.value_out},
                s_if.borrow_out, s_if.zero);
    end
    s_if.sub = 1'b0;
    push(16'h0000, 1'b0, 1'b1);
    tick();
    check_pop("sat_idle", {8'h00, s_if.value_out},
              s_if.borrow_out, s_if.zero);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    lo_if.load = 1'b1;
    hi_if.load = 1'b1;
    tick();
    lo_if.load = 1'b0;
    hi_if.load = 1'b0;
    lo_if.sub  = 1'b1;
    push(16'h00FF, 1'b1, 1'b0);
    push(16'hFFFE, 1'b0, 1'b0);
    push(16'hFFFD, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_pop($sformatf("cascade%0d", k),
                {hi_if.value_out, lo_if.value_out},
                lo_if.borrow_out, lo_if.zero & hi_if.zero);
    end
    lo_if.sub = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
